vip_frame_scheduler: RTL and testbench
======================================

VIP_FRAME_SCHEDULER -- requirements
Module: vip_frame_scheduler

Interface
REQ-001 Parameter IMG_HDISP, 10'd640, active pixels per line.
REQ-002 Parameter IMG_VDISP, 10'd480, active lines per frame.
REQ-003 Parameter DRAIN_CYC, 8'd4, cycles after end-of-frame allowed for the median-filter pipeline to empty.
REQ-004 clk  in  1  cmos video pixel clock; the block's only clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ctrl_en  in  1  run enable; sampled every cycle.
REQ-007 cfg_valid  in  1  new per-frame configuration offered.
REQ-008 cfg_bypass  in  1  configuration: 1 = route raw Y, 0 = route median-filtered Y.
REQ-009 cfg_ready  out  1  configuration accepted this cycle when cfg_valid is also high.
REQ-010 per_frame_vsync, per_frame_href, per_frame_clken  in  1 each  input video timing; vsync high during the frame.
REQ-011 filt_sel  out  1  output-mux select to the filter path; 1 = filtered, 0 = bypass.
REQ-012 frame_start, frame_done  out  1 each  single-cycle pulses.
REQ-013 frame_cnt  out  16  completed-frame count.
REQ-014 err_hsize, err_vsize  out  1 each  sticky geometry-error flags.
REQ-015 state  out  2  current FSM state, for debug.

Function
REQ-016 FSM states: IDLE=0, WAIT_SOF=1, ACTIVE=2, DRAIN=3.
REQ-017 IDLE goes to WAIT_SOF when ctrl_en=1 and per_frame_vsync=0; entry never occurs while vsync is high, so partial frames are never tracked.
REQ-018 WAIT_SOF goes to ACTIVE on a vsync rising edge (registered vsync 0, current 1); frame_start pulses in that same cycle.
REQ-019 ACTIVE goes to DRAIN on a vsync falling edge.
REQ-020 DRAIN counts DRAIN_CYC cycles; on the last count it pulses frame_done, increments frame_cnt, and goes to WAIT_SOF, or to IDLE if ctrl_en=0.
REQ-021 ctrl_en deasserted in WAIT_SOF goes to IDLE next cycle; deasserted in ACTIVE or DRAIN, the current frame completes first.
REQ-022 cfg_ready=1 only in IDLE and WAIT_SOF; a transfer (cfg_valid & cfg_ready) latches cfg_bypass into a pending register and sets pend_vld.
REQ-023 At the frame_start cycle, filt_sel takes the value ~pending if pend_vld=1, and pend_vld clears; otherwise filt_sel holds.
REQ-024 filt_sel is constant from frame_start through frame_done; a config transfer in the same cycle as the SOF edge applies to the next frame, not the current one.
REQ-025 Pixel counter (11 bit) increments on per_frame_href & per_frame_clken in ACTIVE.
REQ-026 On each href falling edge, err_hsize is set if the pixel count != IMG_HDISP; the pixel counter then clears and the line counter (10 bit, saturating at 1023) increments.
REQ-027 On the vsync falling edge, err_vsize is set if the line count != IMG_VDISP; the line counter then clears.
REQ-028 Error flags are sticky until rst.
REQ-029 frame_cnt wraps from 16'hFFFF to 0.
REQ-030 href/clken activity outside ACTIVE is ignored.
REQ-031 All outputs are registered; latency of frame_start from the vsync edge is 1 cycle after the sampled edge.

Reset
REQ-032 rst=1 for one or more clk cycles sets: state=IDLE, filt_sel=1, pend_vld=0, frame_start=0, frame_done=0, frame_cnt=0, err_hsize=0, err_vsize=0, cfg_ready=0, all counters 0, registered vsync/href=1.
REQ-033 Reset mid-frame abandons the frame with no frame_done; tracking resumes only after vsync is seen low (REQ-017).

Structure
REQ-034 The FSM state encodings and default DRAIN_CYC belong in a shared vip package.
REQ-035 An edge-detect sub-module, vip_edge_det (registered rise/fall pulses), is instantiated for vsync and href.
REQ-036 The scheduler drives the mux select only; the median-filter instance is not inside this block.

Verification
REQ-037 rst, ctrl_en=1, one 640x480 frame -> frame_start once, frame_done DRAIN_CYC+1 cycles after vsync falls, frame_cnt=1, no errors.
REQ-038 cfg_bypass=1 transferred in WAIT_SOF -> filt_sel=0 from next frame_start; cfg_valid held during ACTIVE -> cfg_ready=0, no change.
REQ-039 Frame with one 639-pixel line and 481 lines -> err_hsize=1 and err_vsize=1 after that frame, both still 1 after a clean frame.
REQ-040 Reset asserted mid-ACTIVE, released while vsync high -> state=IDLE, no frame_start until vsync falls then rises.
REQ-041 ctrl_en dropped mid-ACTIVE -> frame completes with frame_done, state=IDLE; frame_cnt preset 16'hFFFF wraps to 0.

Source files
------------

// File: rtl/vip_frame_scheduler_pkg.sv
// Shared definitions for the VIP frame scheduler: FSM encoding and defaults.
package vip_frame_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DRAIN    = 2'd3
    } sched_state_e;

    localparam logic [9:0] IMG_HDISP_DEF = 10'd640;
    localparam logic [9:0] IMG_VDISP_DEF = 10'd480;
    localparam logic [7:0] DRAIN_CYC_DEF = 8'd4;

    localparam int PIX_CNT_W  = 11;
    localparam int LINE_CNT_W = 10;

    // Configuration may only be taken between frames.
    function automatic logic cfg_open(sched_state_e s);
        return (s == ST_IDLE) || (s == ST_WAIT_SOF);
    endfunction

endpackage

// File: rtl/vip_frame_scheduler_if.sv
// Config handshake and incoming video timing grouped as one bundle.
interface vip_frame_scheduler_if;
    logic cfg_valid;
    logic cfg_bypass;
    logic cfg_ready;
    logic per_frame_vsync;
    logic per_frame_href;
    logic per_frame_clken;

    modport master (
        output cfg_valid, cfg_bypass,
        output per_frame_vsync, per_frame_href, per_frame_clken,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_bypass,
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        output cfg_ready
    );
endinterface

// File: rtl/vip_edge_det.sv
// Edge detector: holds the previous sample of a timing strobe and flags
// rise/fall against it. The previous sample resets high so a level that is
// already high out of reset never looks like a rising edge.
module vip_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);
    logic sig_q;

    // Previous-sample register.
    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b1;
        else     sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;
endmodule

// File: rtl/vip_frame_scheduler.sv
// Frame scheduler: tracks whole frames on the video timing, applies a pending
// bypass/filter choice at start of frame, checks frame geometry and counts
// completed frames. Drives the output-mux select only.
module vip_frame_scheduler
    import vip_frame_scheduler_pkg::*;
#(
    parameter logic [9:0] IMG_HDISP = IMG_HDISP_DEF,
    parameter logic [9:0] IMG_VDISP = IMG_VDISP_DEF,
    parameter logic [7:0] DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_en,
    vip_frame_scheduler_if.slave vid,
    output logic                 filt_sel,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt,
    output logic                 err_hsize,
    output logic                 err_vsize,
    output logic [1:0]           state
);
    sched_state_e state_q, state_d;

    logic vs_rise, vs_fall, hr_rise, hr_fall;
    logic sof, drain_last;

    logic [7:0]            drain_cnt_q, drain_cnt_d;
    logic [PIX_CNT_W-1:0]  pix_cnt_q,   pix_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q,  line_cnt_d;
    logic                  err_h_q, err_h_d, err_v_q, err_v_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  filt_sel_q, filt_sel_d;
    logic                  pend_q, pend_d, pend_vld_q, pend_vld_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_done_q, frame_done_d;
    logic                  cfg_ready_q, cfg_ready_d;

    vip_edge_det u_vsync_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (vid.per_frame_vsync),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    vip_edge_det u_href_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (vid.per_frame_href),
        .rise_o (hr_rise),
        .fall_o (hr_fall)
    );

    // A stop request in WAIT_SOF wins over a simultaneous SOF edge.
    assign sof        = (state_q == ST_WAIT_SOF) && ctrl_en && vs_rise;
    assign drain_last = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_CYC - 8'd1);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: only whole frames are tracked; a started frame always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (ctrl_en && !vid.per_frame_vsync) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: if (!ctrl_en)    state_d = ST_IDLE;
                         else if (vs_rise) state_d = ST_ACTIVE;
            ST_ACTIVE:   if (vs_fall)     state_d = ST_DRAIN;
            ST_DRAIN:    if (drain_last)  state_d = ctrl_en ? ST_WAIT_SOF : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered pulses and ready.
    always_comb begin
        frame_start_d = sof;
        frame_done_d  = drain_last;
        cfg_ready_d   = cfg_open(state_d);
    end

    // Counters, geometry checks, frame count and config pending/apply logic.
    always_comb begin
        drain_cnt_d = '0;
        pix_cnt_d   = '0;
        line_cnt_d  = '0;
        err_h_d     = err_h_q;
        err_v_d     = err_v_q;
        frame_cnt_d = frame_cnt_q;
        filt_sel_d  = filt_sel_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;

        if (state_q == ST_DRAIN) drain_cnt_d = drain_cnt_q + 8'd1;

        // Pixel/line counting only inside an active frame; held at zero elsewhere.
        if (state_q == ST_ACTIVE) begin
            pix_cnt_d  = pix_cnt_q;
            line_cnt_d = line_cnt_q;
            if (hr_rise) pix_cnt_d = '0;
            if (vid.per_frame_href && vid.per_frame_clken) pix_cnt_d = pix_cnt_d + 11'd1;
            if (hr_fall) begin
                if (pix_cnt_q != {1'b0, IMG_HDISP}) err_h_d = 1'b1;
                pix_cnt_d = '0;
                if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 10'd1;
            end
            if (vs_fall) begin
                if (line_cnt_q != IMG_VDISP) err_v_d = 1'b1;
                line_cnt_d = '0;
            end
        end

        if (drain_last) frame_cnt_d = frame_cnt_q + 16'd1;

        // Apply the old pending choice first so a same-cycle transfer targets the next frame.
        if (sof && pend_vld_q) begin
            filt_sel_d = ~pend_q;
            pend_vld_d = 1'b0;
        end
        if (vid.cfg_valid && cfg_ready_q) begin
            pend_d     = vid.cfg_bypass;
            pend_vld_d = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_q   <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
            frame_cnt_q   <= '0;
            filt_sel_q    <= 1'b1;
            pend_q        <= 1'b0;
            pend_vld_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_ready_q   <= 1'b0;
        end else begin
            drain_cnt_q   <= drain_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            err_h_q       <= err_h_d;
            err_v_q       <= err_v_d;
            frame_cnt_q   <= frame_cnt_d;
            filt_sel_q    <= filt_sel_d;
            pend_q        <= pend_d;
            pend_vld_q    <= pend_vld_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            cfg_ready_q   <= cfg_ready_d;
        end
    end

    assign vid.cfg_ready = cfg_ready_q;
    assign filt_sel      = filt_sel_q;
    assign frame_start   = frame_start_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_hsize     = err_h_q;
    assign err_vsize     = err_v_q;
    assign state         = state_q;
endmodule

// File: tb/tb_vip_frame_scheduler.sv
// Bench for vip_frame_scheduler: randomized frames against a frame-level model.
module tb_vip_frame_scheduler;
    localparam int HD = 12;
    localparam int VD = 5;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst, ctrl_en;
    logic        filt_sel, frame_start, frame_done, err_hsize, err_vsize;
    logic [15:0] frame_cnt;
    logic [1:0]  state;

    vip_frame_scheduler_if vif ();

    vip_frame_scheduler #(
        .IMG_HDISP (10'(HD)),
        .IMG_VDISP (10'(VD)),
        .DRAIN_CYC (8'(DC))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_en     (ctrl_en),
        .vid         (vif),
        .filt_sel    (filt_sel),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .err_hsize   (err_hsize),
        .err_vsize   (err_vsize),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor: pulse counts, timestamps, select captured at start and any change mid-frame.
    int n_start = 0, n_done = 0, start_cyc = 0, done_cyc = 0, fs_glitch = 0;
    bit in_frame = 0;
    logic fs_frame = 1'b1;
    always @(negedge clk) begin
        if (frame_start) begin
            n_start++; start_cyc = cyc; fs_frame = filt_sel; in_frame = 1;
        end else if (in_frame && filt_sel !== fs_frame) fs_glitch++;
        if (frame_done) begin
            n_done++; done_cyc = cyc; in_frame = 0;
        end
    end

    // Frame-level reference model.
    bit          m_filt, m_pend, m_pend_vld, m_err_h, m_err_v;
    logic [15:0] m_cnt;
    int          rise_cyc, fall_cyc;

    function automatic void model_reset();
        m_filt = 1; m_pend = 0; m_pend_vld = 0; m_err_h = 0; m_err_v = 0; m_cnt = 16'd0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; tick(n); rst = 1'b0; in_frame = 0; model_reset();
    endtask

    task automatic noise(input int n);
        repeat (n) begin
            vif.per_frame_href  = 1'($urandom_range(0, 1));
            vif.per_frame_clken = 1'($urandom_range(0, 1));
            tick(1);
        end
        vif.per_frame_href = 0; vif.per_frame_clken = 0;
        tick(1);
    endtask

    task automatic cfg_xfer(input bit b, output logic rdy);
        vif.cfg_valid = 1; vif.cfg_bypass = b;
        m_pend = b; m_pend_vld = 1;
        @(negedge clk) rdy = vif.cfg_ready;
        tick(1);
        vif.cfg_valid = 0;
    endtask

    // One frame from WAIT_SOF; sof_cfg<0 means no transfer on the SOF cycle.
    task automatic drive_frame(input int nlines, input int bad_line, input int bad_len,
                               input int sof_cfg, input bit hold_cfg, input int drop_line,
                               output int rdy_hi);
        int len, p;
        bit ck;
        rdy_hi = 0;
        vif.per_frame_href = 0; vif.per_frame_clken = 0;
        vif.per_frame_vsync = 1; rise_cyc = cyc;
        if (m_pend_vld) begin m_filt = ~m_pend; m_pend_vld = 0; end
        if (sof_cfg >= 0) begin
            vif.cfg_valid = 1; vif.cfg_bypass = sof_cfg[0];
            m_pend = sof_cfg[0]; m_pend_vld = 1;
        end
        tick(1);
        vif.cfg_valid = hold_cfg; vif.cfg_bypass = 1'($urandom_range(0, 1));
        tick(1 + $urandom_range(0, 2));
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : HD;
            p = 0;
            if (l == drop_line) ctrl_en = 0;
            while (p < len) begin
                ck = ($urandom_range(0, 3) != 0);
                vif.per_frame_href = 1; vif.per_frame_clken = ck;
                if (ck) p++;
                if (hold_cfg && vif.cfg_ready) rdy_hi++;
                tick(1);
            end
            vif.per_frame_href = 0;
            repeat (1 + $urandom_range(0, 2)) begin
                vif.per_frame_clken = 1'($urandom_range(0, 1));
                tick(1);
            end
            if (len != HD) m_err_h = 1;
        end
        vif.per_frame_clken = 0; vif.cfg_valid = 0;
        vif.per_frame_vsync = 0; fall_cyc = cyc;
        if (nlines != VD) m_err_v = 1;
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(posedge clk); #1;
            if (n_done != d0) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1; ctrl_en = 0;
        vif.cfg_valid = 0; vif.cfg_bypass = 0;
        vif.per_frame_vsync = 0; vif.per_frame_href = 0; vif.per_frame_clken = 0;
        tick(3);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
        n_cmp++; if (filt_sel !== 1'b1) begin n_bad++; $display("FAIL rst_filt_sel: got %b want 1", filt_sel); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (err_hsize !== 1'b0 || err_vsize !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b%b want 00", err_hsize, err_vsize); end
        n_cmp++; if (vif.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_ready: got %b want 0", vif.cfg_ready); end
        rst = 0; in_frame = 0; model_reset();
    endtask

    task automatic test_single_frame();
        int s0, d0, r;
        bit ok;
        ctrl_en = 1; tick(2);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL sf_wait_sof: got %0d want 1", state); end
        s0 = n_start; d0 = n_done;
        drive_frame(VD, -1, 0, -1, 0, -1, r);
        wait_done(d0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL sf_done_timeout: got none want frame_done"); end
        n_cmp++; if (n_start - s0 != 1) begin n_bad++; $display("FAIL sf_start_count: got %0d want 1", n_start - s0); end
        n_cmp++; if (start_cyc != rise_cyc + 1) begin n_bad++; $display("FAIL sf_start_lat: got %0d want %0d", start_cyc, rise_cyc + 1); end
        n_cmp++; if (done_cyc != fall_cyc + DC + 1) begin n_bad++; $display("FAIL sf_done_lat: got %0d want %0d", done_cyc, fall_cyc + DC + 1); end
        n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL sf_frame_cnt: got %0d want %0d", frame_cnt, m_cnt); end
        n_cmp++; if (err_hsize !== m_err_h || err_vsize !== m_err_v) begin n_bad++; $display("FAIL sf_err: got %b%b want %b%b", err_hsize, err_vsize, m_err_h, m_err_v); end
        n_cmp++; if (fs_frame !== m_filt) begin n_bad++; $display("FAIL sf_filt_sel: got %b want %b", fs_frame, m_filt); end
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL sf_state_after: got %0d want 1", state); end
    endtask

    task automatic test_cfg();
        int r, d0;
        bit ok;
        logic rdy;
        cfg_xfer(1'b1, rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL cfg_ready_wait: got %b want 1", rdy); end
        d0 = n_done;
        drive_frame(VD, -1, 0, -1, 1, -1, r);
        wait_done(d0, ok);
        n_cmp++; if (!ok || fs_frame !== m_filt) begin n_bad++; $display("FAIL cfg_apply: got %b want %b", fs_frame, m_filt); end
        n_cmp++; if (r != 0) begin n_bad++; $display("FAIL cfg_ready_active: got %0d ready cycles want 0", r); end
        d0 = n_done;
        drive_frame(VD, -1, 0, 0, 0, -1, r);
        wait_done(d0, ok);
        n_cmp++; if (!ok || fs_frame !== m_filt) begin n_bad++; $display("FAIL cfg_sof_same_cycle: got %b want %b", fs_frame, m_filt); end
        d0 = n_done;
        noise(3);
        drive_frame(VD, -1, 0, -1, 0, -1, r);
        wait_done(d0, ok);
        n_cmp++; if (!ok || fs_frame !== m_filt) begin n_bad++; $display("FAIL cfg_sof_next: got %b want %b", fs_frame, m_filt); end
        n_cmp++; if (fs_glitch != 0) begin n_bad++; $display("FAIL cfg_sel_stable: got %0d changes want 0", fs_glitch); end
    endtask

    task automatic test_random();
        int r, d0, act;
        bit ok;
        logic rdy;
        for (int f = 0; f < 8; f++) begin
            noise($urandom_range(0, 4));
            act = $urandom_range(0, 3);
            if (act[0]) cfg_xfer(1'($urandom_range(0, 1)), rdy);
            d0 = n_done;
            drive_frame(VD, -1, 0, act[1] ? int'($urandom_range(0, 1)) : -1, 0, -1, r);
            wait_done(d0, ok);
            n_cmp++; if (!ok || fs_frame !== m_filt) begin n_bad++; $display("FAIL rnd_filt_sel[%0d]: got %b want %b", f, fs_frame, m_filt); end
            n_cmp++; if (done_cyc != fall_cyc + DC + 1 || frame_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd_done[%0d]: got cyc %0d cnt %0d want cyc %0d cnt %0d", f, done_cyc, frame_cnt, fall_cyc + DC + 1, m_cnt); end
        end
        n_cmp++; if (fs_glitch != 0) begin n_bad++; $display("FAIL rnd_sel_stable: got %0d changes want 0", fs_glitch); end
    endtask

    task automatic test_geometry();
        int nl[3] = '{VD + 1, VD, VD - 1};
        int bl[3] = '{HD - 1, HD + 2, HD};
        int r, d0;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            do_reset(2);
            ctrl_en = 1; tick(2);
            d0 = n_done;
            drive_frame(nl[k], 1, bl[k], -1, 0, -1, r);
            wait_done(d0, ok);
            n_cmp++; if (!ok || err_hsize !== m_err_h || err_vsize !== m_err_v) begin n_bad++; $display("FAIL geo_err[%0d]: got %b%b want %b%b", k, err_hsize, err_vsize, m_err_h, m_err_v); end
            d0 = n_done;
            drive_frame(VD, -1, 0, -1, 0, -1, r);
            wait_done(d0, ok);
            n_cmp++; if (!ok || err_hsize !== m_err_h || err_vsize !== m_err_v) begin n_bad++; $display("FAIL geo_sticky[%0d]: got %b%b want %b%b", k, err_hsize, err_vsize, m_err_h, m_err_v); end
        end
    endtask

    task automatic test_reset_mid();
        int s0, d0, r;
        bit ok;
        do_reset(2);
        ctrl_en = 1; tick(2);
        s0 = n_start; d0 = n_done;
        vif.per_frame_vsync = 1; tick(3);
        vif.per_frame_href = 1; vif.per_frame_clken = 1; tick(4);
        vif.per_frame_href = 0; vif.per_frame_clken = 0; tick(1);
        do_reset(2);
        tick(2);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rm_state_idle: got %0d want 0", state); end
        tick(6);
        n_cmp++; if (n_start - s0 != 1 || state !== 2'd0) begin n_bad++; $display("FAIL rm_no_start: got %0d starts state %0d want 1 starts state 0", n_start - s0, state); end
        vif.per_frame_vsync = 0; tick(3);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL rm_resume: got %0d want 1", state); end
        drive_frame(VD, -1, 0, -1, 0, -1, r);
        wait_done(d0, ok);
        n_cmp++; if (!ok || n_start - s0 != 2 || n_done - d0 != 1) begin n_bad++; $display("FAIL rm_frames: got %0d starts %0d dones want 2 1", n_start - s0, n_done - d0); end
        n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL rm_frame_cnt: got %0d want %0d", frame_cnt, m_cnt); end
    endtask

    task automatic test_ctrl_drop_wrap();
        int r, d0;
        bit ok;
        tick(2);
        dut.frame_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        d0 = n_done;
        drive_frame(VD, -1, 0, -1, 0, 2, r);
        wait_done(d0, ok);
        n_cmp++; if (!ok || n_done - d0 != 1) begin n_bad++; $display("FAIL cd_done: got %0d want 1", n_done - d0); end
        n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL cd_wrap: got %h want %h", frame_cnt, m_cnt); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL cd_idle: got %0d want 0", state); end
        tick(3);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL cd_stay_idle: got %0d want 0", state); end
        ctrl_en = 1; tick(2);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL cd_reenable: got %0d want 1", state); end
        ctrl_en = 0; tick(1);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL cd_wait_drop: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_cfg();
        test_random();
        test_geometry();
        test_reset_mid();
        test_ctrl_drop_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
